// File: rtl/rs_decode_sched.sv
// rs_decode_sched: round-robin scheduler feeding one RS decoder with a watchdog on each job
module rs_decode_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1600,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_error_pos,
  output logic                      rsp_timeout,
  output logic                      dec_decode_en,
  output logic                      dec_clrn,
  output logic [DATA_W-1:0]         dec_encoded_data,
  input  logic                      dec_ready,
  input  logic                      dec_output_valid,
  input  logic [DATA_W-1:0]         dec_error_pos,
  output logic                      busy,
  output logic [7:0]                timeout_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, RESP} state_t;
  state_t              state_q, state_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx;
  logic [TW-1:0]       timer_q, timer_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic [DATA_W-1:0]   job_q, job_d, err_q, err_d;
  logic                to_q, to_d, gnt_vld;
  // first requester at or after rr_ptr; descending scan lets the nearest one win
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end
  // next-state logic plus the decoder strobes and the acceptance strobe
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    job_d         = job_q;
    err_d         = err_q;
    to_d          = to_q;
    timer_d       = timer_q;
    tcnt_d        = tcnt_q;
    req_ready     = '0;
    dec_clrn      = 1'b1;
    dec_decode_en = 1'b0;
    case (state_q)
      IDLE: if (gnt_vld && dec_ready) begin
        req_ready = NUM_REQ'(1) << gnt_idx;
        job_d     = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        id_d      = gnt_idx;
        rr_ptr_d  = 3'((int'(gnt_idx) + 1) % NUM_REQ);
        state_d   = CLEAR;
      end
      CLEAR: begin
        dec_clrn = 1'b0;
        state_d  = LAUNCH;
      end
      LAUNCH: begin
        dec_decode_en = 1'b1;
        timer_d       = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (dec_output_valid) begin
          err_d   = dec_error_pos;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT)) begin
          dec_clrn = 1'b0;
          err_d    = '0;
          to_d     = 1'b1;
          tcnt_d   = tcnt_q + 8'(tcnt_q != 8'hff);
          state_d  = RESP;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and job registers; reset discards any job in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      job_q    <= '0;
      err_q    <= '0;
      to_q     <= 1'b0;
      timer_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      job_q    <= job_d;
      err_q    <= err_d;
      to_q     <= to_d;
      timer_q  <= timer_d;
      tcnt_q   <= tcnt_d;
    end
  end
  assign rsp_valid        = state_q == RESP;
  assign busy             = state_q != IDLE;
  assign rsp_id           = id_q;
  assign rsp_error_pos    = err_q;
  assign rsp_timeout      = to_q;
  assign dec_encoded_data = job_q;
  assign timeout_cnt      = tcnt_q;
endmodule

// File: tb/tb_rs_decode_sched.sv
// tb_rs_decode_sched: random jobs against a round-robin/watchdog reference model with a response scoreboard
module tb_rs_decode_sched;
  localparam int N = 4, W = 32, TO = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout, dec_decode_en, dec_clrn, busy;
  logic [2:0] rsp_id;
  logic [W-1:0] rsp_error_pos, dec_encoded_data, dec_error_pos = '0;
  logic dec_ready = 1'b1, dec_output_valid = 1'b0;
  logic [7:0] timeout_cnt;
  int total = 0, bad = 0, ptr_m = 0, tcnt_m = 0, lat_cfg = -1;
  typedef struct {int id; logic [W-1:0] err; logic to; int hold; int tcnt;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit mon_act = 1'b0;
  int mon_held = 0;

  rs_decode_sched #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_error_pos(rsp_error_pos),
    .rsp_timeout(rsp_timeout), .dec_decode_en(dec_decode_en), .dec_clrn(dec_clrn),
    .dec_encoded_data(dec_encoded_data), .dec_ready(dec_ready), .dec_output_valid(dec_output_valid),
    .dec_error_pos(dec_error_pos), .busy(busy), .timeout_cnt(timeout_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  task automatic run_job(input logic [N-1:0] vec, input bit keep, input int lat, input int hold);
    int g, n, clr, en_at;
    logic [W-1:0] data [N];
    logic [W-1:0] key;
    bit to;
    exp_t e;
    g = pick(vec);
    ptr_m = (g + 1) % N;
    for (int i = 0; i < N; i++) begin
      data[i] = $urandom;
      req_data[i*W +: W] = data[i];
    end
    key = $urandom;
    dec_error_pos = key;
    lat_cfg = lat;
    to = (lat < 0) || (lat > TO);
    if (to && tcnt_m < 255) tcnt_m++;
    e.id = g; e.err = to ? '0 : key; e.to = to; e.hold = hold; e.tcnt = tcnt_m;
    exp_q.push_back(e);
    req_valid = vec;
    #1;
    n = 0;
    while (req_ready == '0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", 64'(req_ready), 64'(1) << g);
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
    n = 0; clr = 0; en_at = 0;
    do begin
      @(negedge clk); #1; n++;
      if (!dec_clrn) clr++;
      if (dec_decode_en) en_at = n;
      if (n == 1) chk("enc_data", 64'(dec_encoded_data), 64'(data[g]));
    end while (busy && n < 2000);
    chk("busy_end", 64'(busy), 0);
    chk("launch_lat", en_at, 2);
    chk("clrn_cycles", clr, to ? 2 : 1);
  endtask

  // decoder model: output_valid appears lat cycles into WAIT and stays until cleared or relaunched
  initial begin
    int cnt = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dec_output_valid = 1'b0; cnt = -1;
      end else if (dec_decode_en) begin
        dec_output_valid = 1'b0; cnt = lat_cfg;
      end else if (cnt == 0) begin
        dec_output_valid = 1'b1; cnt = -1;
      end else if (!dec_clrn) begin
        dec_output_valid = 1'b0; cnt = -1;
      end else if (cnt > 0) cnt--;
    end
  end

  // response monitor: pops the scoreboard on each new response and checks it stays stable
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (!mon_act) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 0);
          else begin
            mon_e = exp_q.pop_front(); mon_act = 1'b1; mon_held = 0;
            chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
            chk("rsp_err", 64'(rsp_error_pos), 64'(mon_e.err));
            chk("rsp_to", 64'(rsp_timeout), 64'(mon_e.to));
            chk("tcnt", 64'(timeout_cnt), 64'(mon_e.tcnt));
          end
        end else begin
          chk("hold_id", 64'(rsp_id), 64'(mon_e.id));
          chk("hold_err", 64'(rsp_error_pos), 64'(mon_e.err));
          chk("hold_to", 64'(rsp_timeout), 64'(mon_e.to));
          chk("hold_busy", 64'(busy), 1);
          chk("hold_nogrant", 64'(req_ready), 0);
        end
        rsp_ready = mon_held >= mon_e.hold;
        mon_held++;
      end else begin
        mon_act = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_clrn", 64'(dec_clrn), 1);
    chk("rst_dec_en", 64'(dec_decode_en), 0);
    chk("rst_tcnt", 64'(timeout_cnt), 0);
    chk("rst_rsp_id", 64'(rsp_id), 0);
    chk("rst_rsp_err", 64'(rsp_error_pos), 0);
    chk("rst_rsp_to", 64'(rsp_timeout), 0);
    chk("rst_enc", 64'(dec_encoded_data), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    run_job(4'b0100, 1'b0, 5, 2);
    dec_ready = 1'b0;
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("dec_ready_block", 64'(req_ready), 0);
    end
    dec_ready = 1'b1;
    run_job(4'b0010, 1'b0, 0, 0);
    run_job(4'b1000, 1'b0, 3, 1);
    for (int i = 0; i < 5; i++) run_job(4'b1111, i < 4, 4, 1);
    run_job(4'b0001, 1'b0, -1, 0);
    run_job(4'b0010, 1'b0, 3, 50);
    run_job(4'b0100, 1'b0, TO, 0);
    run_job(4'b1000, 1'b0, TO + 1, 0);
    for (int i = 0; i < 40; i++)
      run_job(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO + 3)), int'($urandom_range(0, 3)));
    req_valid = '0;
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom | 1;
    lat_cfg = -1;
    req_valid = 4'b0100;
    g = pick(req_valid);
    #1;
    n = 0;
    while (req_ready == '0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_job_grant", 64'(req_ready), 64'(1) << g);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    ptr_m = 0; tcnt_m = 0;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 0);
    chk("mid_rst_clrn", 64'(dec_clrn), 1);
    chk("mid_rst_dec_en", 64'(dec_decode_en), 0);
    chk("mid_rst_tcnt", 64'(timeout_cnt), 0);
    chk("mid_rst_rsp_id", 64'(rsp_id), 0);
    chk("mid_rst_enc", 64'(dec_encoded_data), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_no_rsp", 64'(rsp_valid), 0);
    run_job(4'b1001, 1'b0, 2, 0);
    for (int i = 0; i < 258; i++) run_job(4'(1 << (i % N)), 1'b0, -1, 0);
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_decode_sched.md
RS_DECODE_SCHED -- requirements
Module: rs_decode_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, 1600, codeword and error-pattern width (200 bytes).
REQ-003 SHALL have parameter TIMEOUT, 1023, maximum WAIT cycles before a job is aborted.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester job request.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester codeword; slice i belongs to requester i.
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot acceptance strobe.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  result consumed.
REQ-011 SHALL have port rsp_id  output  3  index of the requester owning the result.
REQ-012 SHALL have port rsp_error_pos  output  DATA_W  decoder error pattern.
REQ-013 SHALL have port rsp_timeout  output  1  job aborted by watchdog.
REQ-014 SHALL have port dec_decode_en  output  1  decoder start strobe.
REQ-015 SHALL have port dec_clrn  output  1  decoder synchronous clear, active-low.
REQ-016 SHALL have port dec_encoded_data  output  DATA_W  codeword to decoder.
REQ-017 SHALL have ports dec_ready (1), dec_output_valid (1), dec_error_pos (DATA_W), all inputs from the decoder.
REQ-018 SHALL have ports busy  output  1 (state != IDLE) and timeout_cnt  output  8 (saturating abort count).

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, LAUNCH, WAIT, RESP.
REQ-020 IDLE: when any req_valid and dec_ready=1, grant the first set index at or after rr_ptr, wrapping modulo NUM_REQ; req_ready[g]=1 combinationally in that cycle only.
REQ-021 On the grant edge: latch req_data slice g into the job register, latch rsp_id<=g, set rr_ptr<=(g+1) mod NUM_REQ, go to CLEAR.
REQ-022 dec_encoded_data SHALL be driven from the job register, stable from CLEAR until the next grant.
REQ-023 CLEAR: dec_clrn=0 for exactly one cycle, which clears a sticky dec_output_valid; go to LAUNCH.
REQ-024 LAUNCH: dec_decode_en=1 for exactly one cycle, clear the watchdog timer to 0, go to WAIT.
REQ-025 WAIT: timer increments each cycle; dec_output_valid=1 captures dec_error_pos into rsp_error_pos, sets rsp_timeout=0, go to RESP.
REQ-026 WAIT: when timer==TIMEOUT and dec_output_valid=0, drive dec_clrn=0 that cycle, set rsp_error_pos=0, set rsp_timeout=1, increment timeout_cnt (saturating at 255), go to RESP.
REQ-027 When dec_output_valid and timeout occur in the same cycle, the valid result SHALL win.
REQ-028 RESP: rsp_valid=1 held with stable rsp_id, rsp_error_pos, and rsp_timeout until rsp_ready=1; on that edge go to IDLE.
REQ-029 No grant SHALL occur outside IDLE; req_valid deasserted before grant is not an error; rsp_ready outside RESP is ignored.
REQ-030 A requester re-asserting req_valid during RESP SHALL be served no earlier than IDLE, subject to round-robin order.
REQ-031 Grant-to-dec_decode_en latency SHALL be 2 cycles; result-to-rsp_valid latency SHALL be 1 cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force: state=IDLE, rr_ptr=0, timer=0, timeout_cnt=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_error_pos=0, rsp_timeout=0, dec_decode_en=0, dec_clrn=1, busy=0, job register=0.
REQ-033 Reset mid-job SHALL discard the job with no response; the decoder is cleared by its own reset.

Verification
REQ-034 Single request: req_valid[2]=1, decoder returns pattern P -> req_ready[2] pulse, one dec_clrn=0 cycle, dec_decode_en 2 cycles after grant, rsp_valid with rsp_id=2, rsp_error_pos=P, rsp_timeout=0.
REQ-035 Fairness: all four req_valid held high -> grant order 0,1,2,3,0 across five jobs.
REQ-036 Watchdog: decoder never asserts output_valid -> rsp_timeout=1, rsp_error_pos=0, dec_clrn=0 at TIMEOUT, timeout_cnt=1.
REQ-037 Backpressure: rsp_ready held 0 for 50 cycles -> rsp outputs stable, no new grant, busy=1.
REQ-038 Collision: dec_output_valid rises on the TIMEOUT cycle -> rsp_timeout=0, timeout_cnt unchanged.
REQ-039 Reset mid-WAIT -> all outputs at reset values, no rsp_valid, next request granted from index 0.
